// File: rtl/i2c_slave_bit_pkg.sv
// i2c_pkg: bit-level command/event codes shared with the master bit block, plus target FSM states
package i2c_pkg;
  typedef enum logic [2:0] {
    BIT_NONE   = 3'b000,
    BIT_START  = 3'b010,
    BIT_STOP   = 3'b011,
    BIT_DATA_0 = 3'b100,
    BIT_DATA_1 = 3'b101,
    BIT_ACK    = 3'b110,
    BIT_NACK   = 3'b111
  } bit_code_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOW,
    S_DRIVE,
    S_HIGH,
    S_DONE
  } state_t;
endpackage

// File: rtl/i2c_slave_bit_if.sv
// i2c_slave_bit_if: raw bus lines, drive request/handshake and event report of the target bit block
interface i2c_slave_bit_if;
  logic       scl_in;
  logic       sda_in;
  logic       go;
  logic [2:0] command;
  logic       finish;
  logic       sda_oe;
  logic       event_valid;
  logic [2:0] event_code;
  modport master (output scl_in, sda_in, go, command, input finish, sda_oe, event_valid, event_code);
  modport slave (input scl_in, sda_in, go, command, output finish, sda_oe, event_valid, event_code);
endinterface

// File: rtl/i2c_input_filter.sv
// i2c_input_filter: 2-flop synchronizer followed by a stable-count glitch filter
module i2c_input_filter #(
  parameter int FILTER_LEN = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic line,
  output logic line_next
);
  logic [1:0] sync;
  logic [3:0] count;
  logic       differ;
  assign differ    = sync[1] != line;
  assign line_next = (differ && count == 4'(FILTER_LEN - 1)) ? sync[1] : line;
  // Filtered line follows the synchronized one only after a persistent difference
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync  <= 2'b11;
      count <= '0;
      line  <= 1'b1;
    end else begin
      sync  <= {sync[0], raw};
      count <= (differ && line_next == line) ? count + 4'd1 : '0;
      line  <= line_next;
    end
endmodule

// File: rtl/i2c_slave_bit.sv
// i2c_slave_bit: target-side bit responder reporting START/STOP/data and driving one bit on request
module i2c_slave_bit
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = 2
) (
  input logic           clock,
  input logic           reset_n,
  i2c_slave_bit_if.slave bus
);
  logic   scl, sda, scl_nx, sda_nx;
  logic   start_q, stop_q, rise_q, fall_q, cond_seen, data_bit, pull;
  logic   scl_rise_nx, scl_fall_nx, start_nx, stop_nx, cond, data_ev;
  state_t state;
  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clock(clock), .reset_n(reset_n), .raw(bus.scl_in), .line(scl), .line_next(scl_nx)
  );
  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clock(clock), .reset_n(reset_n), .raw(bus.sda_in), .line(sda), .line_next(sda_nx)
  );
  assign scl_rise_nx = !scl && scl_nx;
  assign scl_fall_nx = scl && !scl_nx;
  assign start_nx    = scl && scl_nx && sda && !sda_nx;
  assign stop_nx     = scl && scl_nx && !sda && sda_nx;
  assign cond        = start_q || stop_q;
  assign data_ev     = fall_q && !cond_seen;
  // Edge strobes lag the filtered edge by one cycle; events are registered from them.
  // cond_seen resets high so an SCL fall right after a reset is not reported as a bit.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      cond_seen      <= 1'b1;
      data_bit       <= 1'b0;
      bus.event_valid <= 1'b0;
      bus.event_code  <= BIT_NONE;
    end else begin
      start_q        <= start_nx;
      stop_q         <= stop_nx;
      rise_q         <= scl_rise_nx;
      fall_q         <= scl_fall_nx;
      cond_seen      <= cond || (cond_seen && !rise_q);
      data_bit       <= rise_q ? sda : data_bit;
      bus.event_valid <= cond || data_ev;
      bus.event_code  <= start_q ? BIT_START : stop_q ? BIT_STOP :
                         data_ev ? (data_bit ? BIT_DATA_1 : BIT_DATA_0) : bus.event_code;
    end
  // Drive FSM reacts to SCL edges on the cycle the filtered line changes; a bus condition aborts it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state      <= S_IDLE;
      pull       <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.finish <= 1'b0;
    end else if (state != S_IDLE && cond) begin
      state      <= S_IDLE;
      bus.sda_oe <= 1'b0;
      bus.finish <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.sda_oe <= 1'b0;
          bus.finish <= 1'b0;
          if (bus.go && !bus.finish && bus.command[2]) begin
            pull  <= !bus.command[0];
            state <= S_WAIT_LOW;
          end
        end
        S_WAIT_LOW:
          if (!scl) begin
            bus.sda_oe <= pull;
            state      <= S_DRIVE;
          end
        S_DRIVE:
          if (scl_rise_nx) state <= S_HIGH;
        S_HIGH:
          if (scl_fall_nx) begin
            bus.sda_oe <= 1'b0;
            bus.finish <= 1'b1;
            state      <= S_DONE;
          end
        default: begin
          bus.finish <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_i2c_slave_bit.sv
// tb_i2c_slave_bit: table vectors, hand sequences and randomized I2C transactions against a bus-level model
module tb_i2c_slave_bit;
  import i2c_pkg::*;
  typedef struct {
    int         cyc;
    logic [2:0] code;
  } ev_t;
  typedef struct {
    logic       scl;
    logic       sda;
    int         hold;
    int         n_ev;
    logic [2:0] code;
    int         dly;
  } vec_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1, m_sda = 1'b1, wired = 1'b1;
  int   cyc = 0, t_set = 0, n_cmp = 0, n_bad = 0;
  ev_t  log_q[$], exp_q[$];
  vec_t tbl[19];
  i2c_slave_bit_if bus ();
  i2c_slave_bit #(.FILTER_LEN(2)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~(wired & bus.sda_oe);
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    #1;
    if (bus.event_valid === 1'b1) log_q.push_back('{cyc, bus.event_code});
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic set_bus(input logic scl, input logic sda);
    m_scl = scl;
    m_sda = sda;
    t_set = cyc;
  endtask
  task automatic do_start;
    if (!m_scl) begin
      set_bus(1'b0, 1'b1);
      tick(10);
      set_bus(1'b1, 1'b1);
      tick(20);
    end
    set_bus(1'b1, 1'b0);
    exp_q.push_back('{t_set + 5, BIT_START});
    tick(20);
    set_bus(1'b0, 1'b0);
    tick(10);
  endtask
  task automatic do_stop;
    set_bus(1'b0, 1'b0);
    tick(10);
    set_bus(1'b1, 1'b0);
    tick(20);
    set_bus(1'b1, 1'b1);
    exp_q.push_back('{t_set + 5, BIT_STOP});
    tick(20);
  endtask
  task automatic do_bit(input logic b, input logic issue, input logic [2:0] cmd);
    logic valid, pull, seen;
    int   oe_bad;
    valid = issue && cmd[2];
    pull  = valid && !cmd[0];
    seen  = b && !pull;
    set_bus(1'b0, b);
    if (issue) begin
      bus.go      = 1'b1;
      bus.command = cmd;
    end
    tick(1);
    bus.go = 1'b0;
    tick(10);
    set_bus(1'b1, b);
    oe_bad = 0;
    repeat (20) begin
      tick(1);
      if (bus.sda_oe !== pull) oe_bad++;
    end
    chk("oe_high_phase", oe_bad, 0);
    set_bus(1'b0, b);
    exp_q.push_back('{t_set + 5, seen ? BIT_DATA_1 : BIT_DATA_0});
    tick(3);
    chk("oe_before_drop", int'(bus.sda_oe), int'(pull));
    chk("finish_early", int'(bus.finish), 0);
    tick(1);
    chk("oe_after_drop", int'(bus.sda_oe), 0);
    chk("finish_pulse", int'(bus.finish), int'(valid));
    tick(1);
    chk("finish_width", int'(bus.finish), 0);
    tick(5);
  endtask
  task automatic cmp_queues(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_code%0d", name, i), int'(log_q[i].code), int'(exp_q[i].code));
      chk($sformatf("%s_cyc%0d", name, i), log_q[i].cyc, exp_q[i].cyc);
    end
    log_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int s0, oe_bad, fin;
    tbl[0]  = '{1'b1, 1'b1, 20, 0, BIT_NONE, 0};
    tbl[1]  = '{1'b1, 1'b0, 20, 1, BIT_START, 5};
    tbl[2]  = '{1'b0, 1'b0, 20, 0, BIT_NONE, 0};
    tbl[3]  = '{1'b0, 1'b1, 10, 0, BIT_NONE, 0};
    tbl[4]  = '{1'b1, 1'b1, 20, 0, BIT_NONE, 0};
    tbl[5]  = '{1'b0, 1'b1, 10, 1, BIT_DATA_1, 5};
    tbl[6]  = '{1'b0, 1'b0, 10, 0, BIT_NONE, 0};
    tbl[7]  = '{1'b1, 1'b0, 20, 0, BIT_NONE, 0};
    tbl[8]  = '{1'b0, 1'b0, 10, 1, BIT_DATA_0, 5};
    tbl[9]  = '{1'b0, 1'b1, 10, 0, BIT_NONE, 0};
    tbl[10] = '{1'b1, 1'b1, 20, 0, BIT_NONE, 0};
    tbl[11] = '{1'b0, 1'b1, 10, 1, BIT_DATA_1, 5};
    tbl[12] = '{1'b0, 1'b0, 10, 0, BIT_NONE, 0};
    tbl[13] = '{1'b1, 1'b0, 20, 0, BIT_NONE, 0};
    tbl[14] = '{1'b1, 1'b1, 20, 1, BIT_STOP, 5};
    tbl[15] = '{1'b1, 1'b0, 1, 0, BIT_NONE, 0};
    tbl[16] = '{1'b1, 1'b1, 20, 0, BIT_NONE, 0};
    tbl[17] = '{1'b1, 1'b0, 2, 0, BIT_NONE, 0};
    tbl[18] = '{1'b1, 1'b1, 20, 2, BIT_STOP, 3};
    bus.go = 1'b0;
    bus.command = 3'b000;
    tick(3);
    chk("rst_sda_oe", int'(bus.sda_oe), 0);
    chk("rst_finish", int'(bus.finish), 0);
    chk("rst_event_valid", int'(bus.event_valid), 0);
    chk("rst_event", int'(bus.event_code), 0);
    reset_n = 1'b1;
    tick(10);
    for (int i = 0; i < 19; i++) begin
      s0 = log_q.size();
      set_bus(tbl[i].scl, tbl[i].sda);
      tick(tbl[i].hold);
      chk($sformatf("vec%0d_events", i), log_q.size() - s0, tbl[i].n_ev);
      if (tbl[i].n_ev > 0 && log_q.size() > s0) begin
        chk($sformatf("vec%0d_code", i), int'(log_q[log_q.size() - 1].code), int'(tbl[i].code));
        chk($sformatf("vec%0d_delay", i), log_q[s0].cyc - t_set, tbl[i].dly);
      end
    end
    log_q.delete();
    exp_q.delete();
    do_start;
    repeat (8) do_bit(1'($urandom_range(0, 1)), 1'b0, 3'b000);
    do_bit(1'b1, 1'b1, BIT_ACK);
    do_stop;
    cmp_queues("ack");
    for (int t = 0; t < 5; t++) begin
      do_start;
      repeat ($urandom_range(1, 9))
        do_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1) begin
        do_start;
        repeat ($urandom_range(1, 4))
          do_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
      end
      do_stop;
      cmp_queues($sformatf("rand%0d", t));
    end
    do_start;
    set_bus(1'b0, 1'b0);
    bus.go = 1'b1;
    bus.command = BIT_DATA_0;
    tick(1);
    bus.go = 1'b0;
    tick(10);
    set_bus(1'b1, 1'b0);
    tick(10);
    chk("abort_oe_in_high", int'(bus.sda_oe), 1);
    wired = 1'b0;
    set_bus(1'b1, 1'b1);
    exp_q.push_back('{t_set + 5, BIT_STOP});
    tick(4);
    chk("abort_oe_pending", int'(bus.sda_oe), 1);
    tick(1);
    chk("abort_oe_released", int'(bus.sda_oe), 0);
    tick(5);
    set_bus(1'b0, 1'b1);
    fin = 0;
    repeat (20) begin
      tick(1);
      fin += int'(bus.finish);
    end
    chk("abort_no_finish", fin, 0);
    set_bus(1'b1, 1'b1);
    tick(20);
    wired = 1'b1;
    cmp_queues("abort");
    do_start;
    set_bus(1'b0, 1'b1);
    bus.go = 1'b1;
    bus.command = BIT_ACK;
    tick(1);
    bus.go = 1'b0;
    tick(3);
    chk("drive_before_reset", int'(bus.sda_oe), 1);
    reset_n = 1'b0;
    #1;
    chk("reset_async_oe", int'(bus.sda_oe), 0);
    tick(1);
    reset_n = 1'b1;
    s0 = log_q.size();
    oe_bad = 0;
    repeat (15) begin
      tick(1);
      if (bus.sda_oe !== 1'b0 || bus.finish !== 1'b0) oe_bad++;
    end
    set_bus(1'b1, 1'b1);
    repeat (20) begin
      tick(1);
      if (bus.sda_oe !== 1'b0 || bus.finish !== 1'b0) oe_bad++;
    end
    chk("reset_idle_outputs", oe_bad, 0);
    chk("reset_quiet_events", log_q.size() - s0, 0);
    do_start;
    do_stop;
    cmp_queues("post_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave_bit.md
# i2c_slave_bit

Bit-level I2C responder: the target-side counterpart of the master bit generator. It oversamples `scl`/`sda` from the bus, filters glitches, and reports START, STOP and received data bits to the target byte controller. On command, it drives one bit onto `sda` through an open-drain enable: a data bit for target transmit, or ACK/NACK.

## Interface
Parameters:
- `FILTER_LEN`, default 2: consecutive stable samples (after sync) required before a filtered line changes; legal range 1..15.

Ports:
- `clock` input 1: single system clock, oversamples the bus.
- `reset_n` input 1: asynchronous, active-low reset.
- `scl_in` input 1: raw bus SCL, asynchronous.
- `sda_in` input 1: raw bus SDA, asynchronous.
- `go` input 1: request to drive the bit given by `command`.
- `command` input 3: DATA_0=3'b100, DATA_1=3'b101, ACK=3'b110, NACK=3'b111; all other codes are ignored.
- `finish` output 1: one-cycle pulse when the driven bit's SCL low-high-low cycle is complete.
- `sda_oe` output 1: 1 pulls SDA low, 0 releases it. SCL is never driven.
- `event_valid` output 1: one-cycle pulse qualifying `event`.
- `event` output 3: START_BIT=3'b010, STOP_BIT=3'b011, DATA_0=3'b100, DATA_1=3'b101.

## Operation
- **Input path.** Each line has a 2-flop synchronizer (reset to 1) followed by a glitch filter. The filtered value (reset 1) takes the synchronized value once that value has differed from it for `FILTER_LEN` consecutive cycles; any return to the filtered value clears the count.
- **Condition detection** on filtered signals, previous-cycle versus current:
  - START: `sda` falls while `scl`=1.
  - STOP: `sda` rises while `scl`=1.
  - Either condition sets `cond_seen`.
- **Data reception.**
  - At an `scl` rising edge: latch `sda` and clear `cond_seen`.
  - At an `scl` falling edge with `cond_seen`=0: emit DATA_0 or DATA_1 from the latched bit.
  - Bits are reported even when this block drives SDA, so an own ACK is seen as DATA_0.
- **Drive FSM.**
  - IDLE: `sda_oe`=0. If `go`=1, `finish`=0 and `command` is valid, latch `pull` (1 for DATA_0 and ACK) and go to WAIT_LOW.
  - WAIT_LOW: go to DRIVE once filtered `scl`=0, in the same cycle if `scl` is already low.
  - DRIVE: `sda_oe`=`pull`. On filtered `scl` rising edge go to HIGH.
  - HIGH: `sda_oe`=`pull`. On filtered `scl` falling edge go to DONE.
  - DONE: `sda_oe`=0, `finish`=1, then return to IDLE.
- **Abort.** START or STOP detected in any non-IDLE state forces IDLE with `sda_oe`=0 on the next cycle. No `finish` is produced; the event is still reported.

## Timing
- Reset values: `sda_oe`=0, `finish`=0, `event_valid`=0, `event`=3'b000, FSM=IDLE.
- Asynchronous reset mid-drive releases SDA immediately.
- Latency from a raw line change to the filtered change is 2+`FILTER_LEN` clock edges.
- `event_valid` and `event` are registered: they assert the cycle after the filtered edge, i.e. 3+`FILTER_LEN` edges after the raw edge.
- IDLE to WAIT_LOW takes 1 cycle after `go` is sampled. `sda_oe` asserts the cycle after WAIT_LOW sees `scl`=0.
- `finish` is high for exactly one cycle. A new `go` is accepted from the following IDLE cycle onward; `go` held high simply restarts with the current `command`.
- When START/STOP and an `scl` edge occur in the same cycle, the condition takes priority for `cond_seen`.
- The bus is assumed not to violate I2C, which makes simultaneous SCL and SDA edges ambiguous; treat such a case as no condition.

## Structure
- Shared package `i2c_pkg` holds the 3-bit command/event codes, shared with the master bit block, and the FSM state encoding.
- One sub-module, `i2c_input_filter` (synchronizer plus glitch filter, parameter `FILTER_LEN`), instantiated twice.

## Test plan
All scenarios use `FILTER_LEN`=2 and a 40-cycle SCL period.
- **START, then bits.** Drop SDA with SCL high, then clock bits 1,0,1. Expect `event` sequence 010, 101, 100, 101, with each pulse 5 cycles after the respective raw edge. No DATA event for the SCL fall that follows START.
- **STOP.** Raise SDA with SCL high. Expect one 011 event, with no DATA event.
- **Glitch rejection.** Apply a 1-cycle SDA low pulse with SCL high. Expect no event. A 2-cycle pulse must produce START then STOP.
- **ACK drive.** After the 8th SCL fall, assert `go`=1 with `command`=110.
  - `sda_oe`=1 through the 9th SCL high phase.
  - `sda_oe` drops together with a 1-cycle `finish`, 4 cycles after the raw SCL fall.
  - A DATA_0 event is reported.
- **Abort.** Issue `go` with DATA_0, then the master issues STOP while the FSM is in HIGH. Expect `sda_oe`→0, no `finish`, and event 011.
- **Reset mid-drive.** Pulse `reset_n` low in DRIVE. Expect `sda_oe`=0 asynchronously, FSM in IDLE, and no events until the next valid condition.
